// File: rtl/conv_pad_sequencer_pkg.sv
// Shared types and sizing helpers for the conv2d zero-pad frame sequencer.
// Sizing is derived from WIDTH; the defaults correspond to the 112x112 frame.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 112;
  localparam int P         = WIDTH_DEF + 2;
  localparam int PIX_TOTAL = WIDTH_DEF * WIDTH_DEF;
  localparam int POS_W     = $clog2(P);
  localparam int CNT_W     = $clog2(PIX_TOTAL + 1);

  function automatic int pad_side(input int w);
    return w + 2;
  endfunction

  function automatic int pos_width(input int w);
    return $clog2(w + 2);
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(w * w + 1);
  endfunction

endpackage

// File: rtl/conv_pad_sequencer_pad_pos_counter.sv
// Row/column walker over the padded P x P frame, column fastest.
// Flags border positions and the final (P-1,P-1) position.
module pad_pos_counter #(
  parameter int P_SIDE  = 114,
  parameter int POS_W_P = $clog2(P_SIDE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [POS_W_P-1:0] row,
  output logic [POS_W_P-1:0] col,
  output logic               border,
  output logic               last
);

  localparam logic [POS_W_P-1:0] MAX_POS = POS_W_P'(P_SIDE - 1);

  logic [POS_W_P-1:0] row_q, row_d;
  logic [POS_W_P-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_q == MAX_POS) begin
        col_d = '0;
        // Wrapping the row as well leaves the walker at (0,0) after the last pixel.
        row_d = (row_q == MAX_POS) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row    = row_q;
  assign col    = col_q;
  assign border = (row_q == '0) || (row_q == MAX_POS) || (col_q == '0) || (col_q == MAX_POS);
  assign last   = (row_q == MAX_POS) && (col_q == MAX_POS);

endmodule

// File: rtl/conv_pad_sequencer.sv
// Frame controller: streams a zero-bordered (WIDTH+2)^2 frame to the conv filter
// and counts its outputs. CONV_SEQ_WATCHDOG_EN adds a stall watchdog with an err flag.
module conv_pad_sequencer
  import conv_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112
`ifdef CONV_SEQ_WATCHDOG_EN
  ,
  parameter int WD_CYCLES  = 4096
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3*DATA_WIDTH-1:0] src_data,
  input  logic                    src_empty,
  output logic                    src_rdreq,
  output logic [3*DATA_WIDTH-1:0] filt_data,
  output logic                    filt_empty,
  input  logic                    filt_rdreq,
  input  logic                    filt_valid,
  output logic                    busy,
  output logic                    done
`ifdef CONV_SEQ_WATCHDOG_EN
  ,
  output logic                    err
`endif
);

  localparam int PAD_SIDE = pad_side(WIDTH);
  localparam int ROW_W    = pos_width(WIDTH);
  localparam int OUT_W    = cnt_width(WIDTH);
  localparam logic [OUT_W-1:0] PIX_CNT = OUT_W'(WIDTH * WIDTH);

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               start_acc;
  logic               adv;
  logic               active;
  logic               timeout;
  logic               pos_border, pos_last;
  logic [ROW_W-1:0]   pos_row, pos_col;

  pad_pos_counter #(
    .P_SIDE  (PAD_SIDE),
    .POS_W_P (ROW_W)
  ) u_pos (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_acc),
    .en     (adv),
    .row    (pos_row),
    .col    (pos_col),
    .border (pos_border),
    .last   (pos_last)
  );

  assign active = (state_q == STREAM) || (state_q == DRAIN);
  assign adv    = (state_q == STREAM) && filt_rdreq && !filt_empty;

`ifdef CONV_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WD_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  assign timeout = active && (wd_q == WD_LIMIT);

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (!active || adv || filt_valid) begin
      wd_d = '0;
    end else if (wd_q != WD_LIMIT) begin
      wd_d = wd_q + 1'b1;
    end
    if (start_acc) begin
      err_d = 1'b0;
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: if (adv && pos_last) state_d = DRAIN;
      DRAIN:  if (out_cnt_q == PIX_CNT) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A stalled frame is abandoned but still signals completion.
    if (timeout) state_d = DONE;
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (start_acc) begin
      out_cnt_d = '0;
    end else if (active && filt_valid && (out_cnt_q != PIX_CNT)) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_comb begin
    filt_data  = '0;
    filt_empty = 1'b1;
    src_rdreq  = 1'b0;
    if (state_q == STREAM) begin
      if (pos_border) begin
        filt_empty = 1'b0;
      end else begin
        filt_data  = src_data;
        filt_empty = src_empty;
        src_rdreq  = filt_rdreq && !src_empty;
      end
    end
  end

  assign busy = active;
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_conv_pad_sequencer.sv
// Scoreboard bench for conv_pad_sequencer at WIDTH=4 (6x6 padded, 16 outputs).
// Build with CONV_SEQ_WATCHDOG_EN to exercise the watchdog path.
module tb_conv_pad_sequencer;

  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int P    = W + 2;
  localparam int PW   = 3 * DW;
  localparam int NPIX = W * W;
  localparam int NPAD = P * P;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] src_data = '0;
  logic          src_empty = 1'b1;
  logic          src_rdreq;
  logic [PW-1:0] filt_data;
  logic          filt_empty;
  logic          filt_rdreq = 1'b0;
  logic          filt_valid = 1'b0;
  logic          busy;
  logic          done;
`ifdef CONV_SEQ_WATCHDOG_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  conv_pad_sequencer #(
    .DATA_WIDTH (DW),
    .WIDTH      (W)
`ifdef CONV_SEQ_WATCHDOG_EN
    ,
    .WD_CYCLES  (8)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_data   (src_data),
    .src_empty  (src_empty),
    .src_rdreq  (src_rdreq),
    .filt_data  (filt_data),
    .filt_empty (filt_empty),
    .filt_rdreq (filt_rdreq),
    .filt_valid (filt_valid),
    .busy       (busy),
    .done       (done)
`ifdef CONV_SEQ_WATCHDOG_EN
    ,
    .err        (err)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] src_q[$];
  logic [PW-1:0] exp_q[$];
  bit pop_pend = 0;
  int adv_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int base, input int i);
    return PW'(32'h010000 * (base + 1) + 32'h000101 * (i + 1));
  endfunction

  task automatic refresh();
    src_empty = (src_q.size() == 0);
    src_data  = src_empty ? '0 : src_q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    if (pop_pend) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      pop_pend = 0;
    end
    #1;
    refresh();
  endtask

  // Monitor: every accepted filter pixel is checked against the scoreboard.
  always @(negedge clk) begin
    logic [PW-1:0] e;
    if (rst) begin
      if (filt_rdreq && !filt_empty) begin
        adv_cnt++;
        if (exp_q.size() == 0) begin
          chk("adv_without_expectation", 32'(adv_cnt), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 32'(filt_data), 32'(e));
          $display("pixel %0d data=%h expected=%h", adv_cnt, filt_data, e);
        end
      end
      if (src_rdreq) begin
        pop_cnt++;
        pop_pend = 1;
        chk("pop_while_empty", 32'(src_empty), 32'(0));
      end
      if (done) done_cnt++;
    end
  end

  task automatic load_exp(input int base);
    int k = 0;
    for (int r = 0; r < P; r++)
      for (int c = 0; c < P; c++)
        if (r == 0 || r == P-1 || c == 0 || c == P-1) exp_q.push_back('0);
        else begin
          exp_q.push_back(pix(base, k));
          k++;
        end
  endtask

  task automatic push_src(input int base, input int from, input int to);
    for (int i = from; i < to; i++) src_q.push_back(pix(base, i));
    refresh();
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    adv_cnt = 0;
    pop_cnt = 0;
    chk("busy_after_start", 32'(busy), 32'(1));
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && adv_cnt < target; i++) tick();
    chk("advance_count", 32'(adv_cnt), 32'(target));
  endtask

  task automatic valids(input int n);
    filt_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    filt_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit start_on_done);
    for (int i = 0; i < budget && !done; i++) tick();
    chk("done_seen", 32'(done), 32'(1));
    if (start_on_done) start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("busy_after_done", 32'(busy), 32'(0));
    $display("frame done, done_cnt=%0d", done_cnt);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_filt_empty", 32'(filt_empty), 32'(1));
    chk("rst_src_rdreq", 32'(src_rdreq), 32'(0));
    chk("rst_filt_data", 32'(filt_data), 32'(0));
`ifdef CONV_SEQ_WATCHDOG_EN
    chk("rst_err", 32'(err), 32'(0));
`endif
  endtask

  initial begin
    int gap;
    int d0;
    // Reset state
    tick();
    tick();
    check_reset_outputs();
    rst = 1'b1;
    tick();
    check_reset_outputs();

    // Full frame, preloaded FIFO, no backpressure
    load_exp(0);
    push_src(0, 0, NPIX);
    filt_rdreq = 1'b1;
    start_frame();
    run_until(NPAD, 100);
    chk("pops_frame_a", 32'(pop_cnt), 32'(NPIX));
    chk("busy_in_drain", 32'(busy), 32'(1));
    valids(NPIX);
    wait_done(4, 1'b0);

    // Underrun: FIFO empty when the first interior pixel is reached
    load_exp(1);
    start_frame();
    run_until(P + 1, 20);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_at_1_1", 32'(adv_cnt), 32'(P + 1));
    chk("stall_filt_empty", 32'(filt_empty), 32'(1));
    push_src(1, 0, W);
    run_until(P + 1 + W + 2, 20);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_at_2_1", 32'(adv_cnt), 32'(P + 1 + W + 2));
    push_src(1, W, NPIX);
    run_until(NPAD, 100);
    chk("pops_frame_b", 32'(pop_cnt), 32'(NPIX));
    valids(NPIX);
    wait_done(4, 1'b0);

    // Backpressure plus ignored start pulses; early valids must not be cleared
    load_exp(2);
    push_src(2, 0, NPIX);
    start_frame();
    gap = 0;
    for (int cyc = 0; cyc < 400 && adv_cnt < NPAD; cyc++) begin
      filt_rdreq = ($urandom_range(0, 1) == 1) || (gap >= 3);
      gap = filt_rdreq ? 0 : gap + 1;
      filt_valid = (cyc < 3);
      start = (cyc == 10) || (cyc == 11);
      tick();
    end
    start = 1'b0;
    filt_valid = 1'b0;
    filt_rdreq = 1'b1;
    chk("advance_count_bp", 32'(adv_cnt), 32'(NPAD));
    chk("pops_frame_c", 32'(pop_cnt), 32'(NPIX));
    valids(NPIX - 4);
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) tick();
    chk("no_early_done", 32'(done_cnt - d0), 32'(0));
    valids(1);
    wait_done(4, 1'b1);
    tick();
    chk("start_on_done_ignored", 32'(busy), 32'(0));

    // Stalled frame: filter stops after 10 outputs
    load_exp(3);
    push_src(3, 0, NPIX);
    start_frame();
    run_until(NPAD, 100);
    valids(10);
`ifdef CONV_SEQ_WATCHDOG_EN
    wait_done(20, 1'b0);
    chk("wd_err_set", 32'(err), 32'(1));
    start_frame();
    chk("wd_err_cleared", 32'(err), 32'(0));
    d0 = 4;
`else
    d0 = done_cnt;
    for (int i = 0; i < 30; i++) tick();
    chk("stalled_no_done", 32'(done_cnt - d0), 32'(0));
    chk("stalled_busy", 32'(busy), 32'(1));
    d0 = 3;
`endif
    // Reset mid-frame discards everything
    rst = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    exp_q.delete();
    src_q.delete();
    pop_pend = 0;
    refresh();
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs();
    chk("done_count", 32'(done_cnt), 32'(d0));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
